uart_tx_fifo: RTL and testbench

Parametrised UART transmitter that extends the single-byte serializer with a transmit FIFO, configurable frame format (data width, parity, stop bits) and an asynchronous active-low reset. It sits between the CPU-side MMIO/debug path and the board TX pin. The producer can queue a burst of characters and is back-pressured only when the FIFO is full. Queued frames are sent back-to-back with no idle gap.

---
 rtl/uart_tx_fifo.sv | 228 ++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : uart_tx_fifo                                                      |
// | Brief  : UART transmitter with a transmit FIFO and configurable framing.   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module uart_tx_fifo #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD_RATE   = 57600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [DATA_BITS-1:0]          i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic                          o_uart_tx,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int c_div    = CLK_FREQ_HZ / BAUD_RATE;
    localparam int c_baud_w = (c_div > 2) ? $clog2(c_div) : 1;
    localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
    localparam int c_bit_w  = $clog2(DATA_BITS);

    localparam logic [c_baud_w-1:0] c_reload    = c_baud_w'(c_div - 1);
    localparam logic [c_bit_w-1:0]  c_last_bit  = c_bit_w'(DATA_BITS - 1);
    localparam logic                c_last_stop = (STOP_BITS == 2);
    localparam logic [c_ptr_w:0]    c_full      = (c_ptr_w + 1)'(FIFO_DEPTH);

    generate
        if (c_div < 2) begin : g_bad_div
            $error("uart_tx_fifo: CLK_FREQ_HZ/BAUD_RATE must be at least 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_fifo: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    // ---------------- FIFO ----------------
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w:0]     r_count;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_fifo_ne;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_head_par;

    assign o_ready      = (r_count != c_full);
    assign w_push       = i_valid & o_ready;
    assign w_fifo_ne    = (r_count != '0);
    assign w_head       = r_mem[r_rd_ptr];
    assign w_head_par   = (PARITY == 1) ? ~^w_head : ^w_head;
    assign o_fifo_count = r_count;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------- Serializer ----------------
    state_e               r_state,    w_state_nxt;
    logic [c_baud_w-1:0]  r_baud,     w_baud_nxt;
    logic [c_bit_w-1:0]   r_bit_idx,  w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift,    w_shift_nxt;
    logic                 r_par,      w_par_nxt;
    logic                 r_stop_idx, w_stop_nxt;
    logic                 r_tx,       w_tx_nxt;
    logic                 w_tick;

    assign w_tick    = (r_baud == '0);
    assign o_uart_tx = r_tx;
    assign o_busy    = (r_state != S_IDLE) | w_fifo_ne;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_baud     <= w_baud_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_par      <= w_par_nxt;
            r_stop_idx <= w_stop_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    // r_tx is loaded with the level of the state being entered, so the line
    // changes on the same edge as the state.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_stop_nxt  = r_stop_idx;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                w_pop    = w_fifo_ne;
            end
            S_START: begin
                if (w_tick) begin
                    w_state_nxt = S_DATA;
                    w_baud_nxt  = c_reload;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                    w_shift_nxt = r_shift >> 1;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_baud_nxt = c_reload;
                    if (r_bit_idx == c_last_bit) begin
                        if (PARITY != 0) begin
                            w_state_nxt = S_PARITY;
                            w_tx_nxt    = r_par;
                        end else begin
                            w_state_nxt = S_STOP;
                            w_tx_nxt    = 1'b1;
                            w_stop_nxt  = 1'b0;
                        end
                    end else begin
                        w_bit_nxt   = r_bit_idx + c_bit_w'(1);
                        w_tx_nxt    = r_shift[0];
                        w_shift_nxt = r_shift >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_state_nxt = S_STOP;
                    w_baud_nxt  = c_reload;
                    w_tx_nxt    = 1'b1;
                    w_stop_nxt  = 1'b0;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_stop_idx == c_last_stop) begin
                        if (w_fifo_ne) begin
                            w_pop = 1'b1;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_stop_nxt = r_stop_idx + 1'b1;
                        w_baud_nxt = c_reload;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase

        if (!w_tick && r_state != S_IDLE) begin
            w_baud_nxt = r_baud - c_baud_w'(1);
        end

        // A pop always starts a new frame, whether from IDLE or straight out of STOP.
        if (w_pop) begin
            w_state_nxt = S_START;
            w_baud_nxt  = c_reload;
            w_shift_nxt = w_head;
            w_par_nxt   = w_head_par;
            w_tx_nxt    = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_uart_tx_fifo                                                   |
// | Brief  : Randomized bench for uart_tx_fifo against a frame-level model.    |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int DIV = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] valid_v;
    logic [7:0] d0, d1, d2;
    logic [6:0] d3;
    logic [3:0] tx_v, busy_v, ready_v;
    logic [4:0] cnt0;
    logic [2:0] cnt1, cnt2, cnt3;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   accept_cyc, fall_cyc, first_count;
    logic last_busy;
    logic [8:0] sb [$];

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // dut0: 8N1 depth 16, dut1: 8E1, dut2: 8O1, dut3: 7N2 (depth 4 each)
    uart_tx_fifo #(.CLK_FREQ_HZ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(d0), .i_valid(valid_v[0]),
        .o_ready(ready_v[0]), .o_uart_tx(tx_v[0]), .o_busy(busy_v[0]), .o_fifo_count(cnt0));
    uart_tx_fifo #(.CLK_FREQ_HZ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
                   .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(d1), .i_valid(valid_v[1]),
        .o_ready(ready_v[1]), .o_uart_tx(tx_v[1]), .o_busy(busy_v[1]), .o_fifo_count(cnt1));
    uart_tx_fifo #(.CLK_FREQ_HZ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
                   .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(d2), .i_valid(valid_v[2]),
        .o_ready(ready_v[2]), .o_uart_tx(tx_v[2]), .o_busy(busy_v[2]), .o_fifo_count(cnt2));
    uart_tx_fifo #(.CLK_FREQ_HZ(1000000), .BAUD_RATE(100000), .DATA_BITS(7),
                   .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(d3), .i_valid(valid_v[3]),
        .o_ready(ready_v[3]), .o_uart_tx(tx_v[3]), .o_busy(busy_v[3]), .o_fifo_count(cnt3));

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int cfg_nb(input int id);    return (id == 3) ? 7 : 8; endfunction
    function automatic int cfg_par(input int id);   return (id == 1) ? 2 : ((id == 2) ? 1 : 0); endfunction
    function automatic int cfg_ns(input int id);    return (id == 3) ? 2 : 1; endfunction
    function automatic int cfg_depth(input int id); return (id == 0) ? 16 : 4; endfunction

    function automatic int get_cnt(input int id);
        case (id)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            2:       return int'(cnt2);
            default: return int'(cnt3);
        endcase
    endfunction

    task automatic set_in(input int id, input logic v, input logic [8:0] d);
        valid_v[id] = v;
        case (id)
            0:       d0 = d[7:0];
            1:       d1 = d[7:0];
            2:       d2 = d[7:0];
            default: d3 = d[6:0];
        endcase
    endtask

    // Frame as one entry per bit period: start, data LSB first, parity, stops.
    function automatic logic [15:0] frame_model(input int id, input logic [8:0] d);
        logic [15:0] f = '0;
        int nb = cfg_nb(id);
        int pos = 1;
        int ones = 0;
        for (int i = 0; i < nb; i++) begin
            f[pos] = d[i];
            ones += int'(d[i]);
            pos++;
        end
        if (cfg_par(id) == 2) begin f[pos] = (ones % 2 == 1); pos++; end
        if (cfg_par(id) == 1) begin f[pos] = (ones % 2 == 0); pos++; end
        for (int s = 0; s < cfg_ns(id); s++) f[pos + s] = 1'b1;
        return f;
    endfunction

    // Samples one frame; bit 15 of the observed word flags a level change inside a bit period.
    task automatic check_frame(input int id, input logic [8:0] d, input bit wait_fall, input string tag);
        int nbits = 1 + cfg_nb(id) + ((cfg_par(id) != 0) ? 1 : 0) + cfg_ns(id);
        logic [15:0] obs = '0;
        logic s;
        int t = 0;
        if (wait_fall) begin
            do begin
                @(negedge clk);
                t++;
            end while (tx_v[id] !== 1'b0 && t < 2000);
            if (tx_v[id] !== 1'b0) begin
                chk_eq({tag, " start timeout"}, 32'd0, 32'd1);
                return;
            end
        end else begin
            @(negedge clk);
        end
        fall_cyc    = cyc;
        first_count = get_cnt(id);
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < DIV; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                s = tx_v[id];
                if (c == 0) obs[b] = s;
                else if (s !== obs[b]) obs[15] = 1'b1;
            end
        end
        last_busy = busy_v[id];
        chk_eq(tag, 32'(obs), 32'(frame_model(id, d)));
    endtask

    // Pushes sb[0..n-1] with i_valid held high while checking every frame on the line.
    task automatic run_burst(input int id, input int n, input string tag);
        int exp_cnt = (n == 1) ? 1 : n - 1;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    @(negedge clk);
                    if (i == 0) accept_cyc = cyc + 1;
                    set_in(id, 1'b1, sb[i]);
                end
                @(negedge clk);
                set_in(id, 1'b0, 9'h000);
                chk_eq({tag, " count after pushes"}, 32'(get_cnt(id)), 32'(exp_cnt));
                chk_eq({tag, " ready after pushes"}, 32'(ready_v[id]), 32'(exp_cnt != cfg_depth(id)));
                chk_eq({tag, " busy after pushes"}, 32'(busy_v[id]), 32'd1);
            end
            begin
                for (int i = 0; i < n; i++) begin
                    check_frame(id, sb[i], (i == 0), $sformatf("%s frame %0d", tag, i));
                    if (i == 0) begin
                        chk_eq({tag, " start latency"}, 32'(fall_cyc - accept_cyc), 32'd1);
                        chk_eq({tag, " count after pop"}, 32'(first_count), 32'((n == 1) ? 0 : 1));
                    end
                end
                chk_eq({tag, " busy in last stop"}, 32'(last_busy), 32'd1);
                @(negedge clk);
                chk_eq({tag, " busy idle"}, 32'(busy_v[id]), 32'd0);
                chk_eq({tag, " line idle"}, 32'(tx_v[id]), 32'd1);
                chk_eq({tag, " count idle"}, 32'(get_cnt(id)), 32'd0);
            end
        join
    endtask

    task automatic fill_random(input int id, input int n);
        sb.delete();
        for (int i = 0; i < n; i++) sb.push_back(9'($urandom_range(0, (1 << cfg_nb(id)) - 1)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        valid_v = '0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        repeat (3) @(negedge clk);
        chk_eq("reset tx",    32'(tx_v[0]),    32'd1);
        chk_eq("reset count", 32'(cnt0),       32'd0);
        chk_eq("reset busy",  32'(busy_v[0]),  32'd0);
        chk_eq("reset ready", 32'(ready_v[0]), 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        sb.delete(); sb.push_back(9'h0A5);
        run_burst(0, 1, "8n1 a5");
        fill_random(0, 2);
        run_burst(0, 2, "push+pop");
        fill_random(0, 17);
        run_burst(0, 17, "burst17");

        sb.delete(); sb.push_back(9'h055);
        run_burst(1, 1, "even 55");
        sb.delete(); sb.push_back(9'h007);
        run_burst(1, 1, "even 07");
        sb.delete(); sb.push_back(9'h055);
        run_burst(2, 1, "odd 55");
        fill_random(2, 5);
        run_burst(2, 5, "odd burst");
        sb.delete(); sb.push_back(9'h041);
        run_burst(3, 1, "7n2 41");
        fill_random(3, 3);
        run_burst(3, 3, "7n2 burst");

        for (int r = 0; r < 3; r++) begin
            fill_random(0, $urandom_range(1, 8));
            run_burst(0, sb.size(), $sformatf("rand %0d", r));
        end

        // Abort mid-frame: first character is 0x00 so the line is low in its data bits.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_in(0, 1'b1, (i == 0) ? 9'h000 : 9'($urandom_range(0, 255)));
        end
        @(negedge clk);
        set_in(0, 1'b0, 9'h000);
        repeat (30) @(negedge clk);
        chk_eq("pre-reset line low", 32'(tx_v[0]), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("async reset tx",    32'(tx_v[0]),    32'd1);
        chk_eq("async reset count", 32'(cnt0),       32'd0);
        chk_eq("async reset ready", 32'(ready_v[0]), 32'd1);
        chk_eq("async reset busy",  32'(busy_v[0]),  32'd0);
        @(negedge clk);
        set_in(0, 1'b1, 9'h0FF);
        @(negedge clk);
        set_in(0, 1'b0, 9'h000);
        chk_eq("push in reset ignored", 32'(cnt0), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        sb.delete(); sb.push_back(9'h03C);
        run_burst(0, 1, "post reset 3c");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
